fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 110 +++++++++++
 tb/tb_fetch_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Compacting in-order instruction queue between fetch and decode, built on one shared circular buffer.
// Define FETCH_QUEUE_BYPASS_EN to forward a packet arriving at an empty queue straight to insts_out.
module fetch_queue #(
    parameter int FETCH_WIDTH = 4,
    parameter int DEQ_WIDTH   = 4,
    parameter int DEPTH       = 16,
    parameter int ENTRY_W     = 32
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [FETCH_WIDTH*ENTRY_W-1:0]     insts_in,
    input  logic [FETCH_WIDTH-1:0]             insts_in_mask,
    input  logic                               insts_in_valid,
    output logic                               full,
    output logic [DEQ_WIDTH*ENTRY_W-1:0]       insts_out,
    output logic [DEQ_WIDTH-1:0]               valid,
    input  logic [$clog2(DEQ_WIDTH+1)-1:0]     deq_count,
    input  logic                               flush,
    output logic [$clog2(DEPTH+1)-1:0]         count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;

    logic               enq_fire;
    logic               bypass;
    logic [CW-1:0]      enq_n;
    logic [CW-1:0]      enq_add;
    logic [CW-1:0]      vis_n;
    logic [CW-1:0]      deq_n;
    logic [CW-1:0]      skip_n;
    logic [CW-1:0]      head_adv;
    logic [CW-1:0]      lane_off [FETCH_WIDTH];
    logic [ENTRY_W-1:0] comp [DEQ_WIDTH];
    logic [FETCH_WIDTH-1:0] wr_en;
    logic [PW-1:0]      wr_addr [FETCH_WIDTH];

    // Depends only on registered count, so fetch never sees a path from insts_in or deq_count.
    assign full     = count > CW'(DEPTH - FETCH_WIDTH);
    assign enq_fire = insts_in_valid && !full && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = enq_fire && (count == '0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        enq_n = '0;
        for (int unsigned l = 0; l < FETCH_WIDTH; l++) begin
            lane_off[l] = enq_n;
            if (insts_in_mask[l]) enq_n = enq_n + CW'(1);
        end
        enq_add = enq_fire ? enq_n : '0;

        for (int unsigned k = 0; k < DEQ_WIDTH; k++) begin
            comp[k] = '0;
            for (int unsigned l = 0; l < FETCH_WIDTH; l++) begin
                if (insts_in_mask[l] && lane_off[l] == CW'(k))
                    comp[k] = insts_in[l*ENTRY_W +: ENTRY_W];
            end
        end

        if (bypass)
            vis_n = (enq_n > CW'(DEQ_WIDTH)) ? CW'(DEQ_WIDTH) : enq_n;
        else
            vis_n = (count > CW'(DEQ_WIDTH)) ? CW'(DEQ_WIDTH) : count;

        // Decode may ask for more than is visible; clamp so head never passes tail.
        deq_n    = (CW'(deq_count) > vis_n) ? vis_n : CW'(deq_count);
        skip_n   = bypass ? deq_n : '0;
        head_adv = bypass ? '0 : deq_n;

        // Lanes consumed straight from the bypass are never stored; the rest pack down to tail.
        for (int unsigned l = 0; l < FETCH_WIDTH; l++) begin
            wr_en[l]   = enq_fire && insts_in_mask[l] && (lane_off[l] >= skip_n);
            wr_addr[l] = tail + PW'(lane_off[l] - skip_n);
        end
    end

    always_comb begin
        insts_out = '0;
        valid     = '0;
        for (int unsigned i = 0; i < DEQ_WIDTH; i++) begin
            valid[i] = CW'(i) < vis_n;
            insts_out[i*ENTRY_W +: ENTRY_W] = bypass ? comp[i] : mem[head + PW'(i)];
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(head_adv);
            tail  <= tail + PW'(enq_add - skip_n);
            count <= count + enq_add - deq_n;
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned l = 0; l < FETCH_WIDTH; l++) begin
            if (wr_en[l]) mem[wr_addr[l]] <= insts_in[l*ENTRY_W +: ENTRY_W];
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the driver queues expected entries, a negedge monitor checks and retires them.
module tb_fetch_queue;
    localparam int FW    = 4;
    localparam int DW    = 4;
    localparam int DEPTH = 16;
    localparam int EW    = 32;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic [FW*EW-1:0]  insts_in;
    logic [FW-1:0]     insts_in_mask;
    logic              insts_in_valid;
    logic              full;
    logic [DW*EW-1:0]  insts_out;
    logic [DW-1:0]     valid;
    logic [2:0]        deq_count;
    logic              flush;
    logic [4:0]        count;

    int n_vec = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] pend[$];
    bit  pend_fire = 1'b0;
    int  byp_used  = 0;
    int  tag       = 32'h100;

    always #5 clock = ~clock;

    fetch_queue #(.FETCH_WIDTH(FW), .DEQ_WIDTH(DW), .DEPTH(DEPTH), .ENTRY_W(EW)) dut (
        .clock(clock), .reset(reset), .insts_in(insts_in), .insts_in_mask(insts_in_mask),
        .insts_in_valid(insts_in_valid), .full(full), .insts_out(insts_out), .valid(valid),
        .deq_count(deq_count), .flush(flush), .count(count)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [127:0] mk(input int base);
        return pack4(32'(base), 32'(base + 1), 32'(base + 2), 32'(base + 3));
    endfunction

    task automatic drive(input logic [3:0] m, input logic v, input logic [127:0] d,
                         input int dq, input logic fl);
        insts_in       = d;
        insts_in_mask  = m;
        insts_in_valid = v;
        deq_count      = 3'(dq);
        flush          = fl;
        pend.delete();
        for (int l = 0; l < FW; l++) if (m[l]) pend.push_back(d[l*EW +: EW]);
        pend_fire = v && !fl && (exp_q.size() <= DEPTH - FW);
    endtask

    task automatic commit();
        @(posedge clock);
        if (flush || reset) exp_q.delete();
        else if (pend_fire)
            for (int k = byp_used; k < pend.size(); k++) exp_q.push_back(pend[k]);
        byp_used  = 0;
        pend_fire = 1'b0;
        #1;
    endtask

    task automatic idle_deq(input int dq);
        drive(4'b0000, 1'b0, '0, dq, 1'b0);
        commit();
    endtask

    always @(negedge clock) begin
        if (reset === 1'b0) begin
            int sz;
            int nv;
            int nd;
            bit use_pend;
            sz       = exp_q.size();
            use_pend = BYP && (sz == 0) && pend_fire;
            nv       = use_pend ? ((pend.size() > DW) ? DW : pend.size()) : ((sz > DW) ? DW : sz);
            chk("mon_count", 128'(count), 128'(sz));
            chk("mon_full", 128'(full), 128'(sz > DEPTH - FW));
            chk("mon_valid", 128'(valid), 128'((1 << nv) - 1));
            for (int i = 0; i < nv; i++)
                chk("mon_slot", 128'(insts_out[i*EW +: EW]), 128'(use_pend ? pend[i] : exp_q[i]));
            nd = (int'(deq_count) > nv) ? nv : int'(deq_count);
            if (use_pend) byp_used = nd;
            else repeat (nd) void'(exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        logic [3:0] masks [4];
        logic [127:0] held;
        masks[0] = 4'b0111; masks[1] = 4'b1011; masks[2] = 4'b1101; masks[3] = 4'b1110;

        reset = 1'b1; insts_in = '0; insts_in_mask = '0; insts_in_valid = 1'b0;
        deq_count = '0; flush = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_valid", 128'(valid), 128'(0));
        chk("rst_full", 128'(full), 128'(0));

        // Full packet A..D
        drive(4'b1111, 1'b1, pack4(32'hA, 32'hB, 32'hC, 32'hD), 0, 1'b0);
        commit();
        chk("t1_valid", 128'(valid), 128'(4'b1111));
        chk("t1_count", 128'(count), 128'(4));
        chk("t1_data", insts_out, pack4(32'hA, 32'hB, 32'hC, 32'hD));
        idle_deq(4);
        chk("t1_drain", 128'(count), 128'(0));

        // Sparse mask: lane1 = X, lane3 = Y
        drive(4'b1010, 1'b1, pack4(32'hDEAD0, 32'h5858, 32'hDEAD2, 32'h5959), 0, 1'b0);
        commit();
        chk("t2_valid", 128'(valid), 128'(4'b0011));
        chk("t2_count", 128'(count), 128'(2));
        chk("t2_data", 128'(insts_out[63:0]), 128'({32'h5959, 32'h5858}));
        idle_deq(2);

        // Fill to 13, refused offer, then drain 2
        for (int p = 0; p < 3; p++) begin
            drive(4'b1111, 1'b1, mk(tag), 0, 1'b0); tag += 4;
            commit();
        end
        drive(4'b0001, 1'b1, mk(tag), 0, 1'b0); tag += 4;
        commit();
        chk("t3_count13", 128'(count), 128'(13));
        chk("t3_full", 128'(full), 128'(1));
        drive(4'b1111, 1'b1, mk(tag), 0, 1'b0); tag += 4;
        commit();
        chk("t3_hold13", 128'(count), 128'(13));
        chk("t3_hold_full", 128'(full), 128'(1));
        idle_deq(2);
        chk("t3_count11", 128'(count), 128'(11));
        chk("t3_not_full", 128'(full), 128'(0));
        repeat (3) idle_deq(4);
        chk("t3_empty", 128'(count), 128'(0));

        // Steady state, 3 in / 3 out per cycle across pointer wrap
        for (int c = 0; c < 40; c++) begin
            drive(masks[c % 4], 1'b1, mk(tag), 3, 1'b0); tag += 4;
            commit();
            chk("t4_count", 128'(count), 128'(BYP ? 0 : 3));
        end
        idle_deq(4);
        chk("t4_empty", 128'(count), 128'(0));

        // Flush beats simultaneous enqueue and dequeue
        drive(4'b1111, 1'b1, mk(tag), 0, 1'b0); tag += 4;
        commit();
        drive(4'b0011, 1'b1, mk(tag), 0, 1'b0); tag += 4;
        commit();
        chk("t5_count6", 128'(count), 128'(6));
        drive(4'b1111, 1'b1, mk(tag), 2, 1'b1); tag += 4;
        commit();
        chk("t5_count", 128'(count), 128'(0));
        chk("t5_valid", 128'(valid), 128'(0));
        chk("t5_full", 128'(full), 128'(0));

        // Over-ask with one entry, then reuse from the shifted head
        drive(4'b0001, 1'b1, mk(tag), 0, 1'b0); tag += 4;
        commit();
        chk("t6_count1", 128'(count), 128'(1));
        idle_deq(4);
        chk("t6_clamp", 128'(count), 128'(0));
        chk("t6_valid", 128'(valid), 128'(0));
        held = pack4(32'h600D0, 32'h600D1, 32'h600D2, 32'h600D3);
        drive(4'b1111, 1'b1, held, 0, 1'b0);
        commit();
        chk("t6_data", insts_out, held);
        idle_deq(4);

`ifdef FETCH_QUEUE_BYPASS_EN
        held = pack4(32'hE, 32'hF, 32'h10, 32'h11);
        drive(4'b1111, 1'b1, held, 4, 1'b0);
        #1;
        chk("t7_byp_valid", 128'(valid), 128'(4'b1111));
        chk("t7_byp_data", insts_out, held);
        commit();
        chk("t7_count", 128'(count), 128'(0));
        chk("t7_valid", 128'(valid), 128'(0));
`endif

        drive(4'b0000, 1'b0, '0, 0, 1'b0);
        commit();
        commit();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
